bus_load_unit: RTL and testbench

- Destination side of the processor's shared 16-bit data bus. The bus multiplexer drives one source onto the bus; this block latches the bus value into the selected destination register(s).
- Holds the architectural registers R, AR, DR, AC, PC and IR, and supports AR/PC/R increment.
- Issues data-RAM write transactions over a req/ack handshake. It sits between the bus multiplexer output and the datapath/memory.

---
 rtl/bus_load_unit.sv | 138 +++++++++++++
 tb/tb_bus_load_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_load_unit.sv
// Destination side of the shared data bus: architectural registers, increments and a DRAM write requester.
// Optional macro BUS_ERR_CHK_EN: suppress multi-destination loads and flag them on sel_err.
module bus_load_unit #(
  parameter int DATA_W     = 16,
  parameter int WR_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] bus_data,
  input  logic [7:0]        load_ctrl,
  input  logic [2:0]        inc_ctrl,
  input  logic              clr_status,
  input  logic              dram_ack,
  output logic [DATA_W-1:0] r,
  output logic [DATA_W-1:0] ar,
  output logic [DATA_W-1:0] dr,
  output logic [DATA_W-1:0] ac,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic              dram_req,
  output logic [DATA_W-1:0] dram_waddr,
  output logic [DATA_W-1:0] dram_wdata,
  output logic              busy,
  output logic              wr_drop,
  output logic              wr_timeout,
  output logic              sel_err
);

  localparam logic [7:0] TO_LAST = 8'(WR_TIMEOUT - 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [6:0]  sel_eff;
  logic        wr_start, drop_set, to_set;
  logic        unused_bits;

  assign unused_bits = load_ctrl[7];

  function automatic logic [DATA_W-1:0] wrap_inc(input logic [DATA_W-1:0] v);
    return v + DATA_W'(1);
  endfunction

`ifdef BUS_ERR_CHK_EN
  logic multi_sel;

  assign multi_sel = |(load_ctrl[6:0] & (load_ctrl[6:0] - 7'd1));
  assign sel_eff   = multi_sel ? 7'd0 : load_ctrl[6:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_err <= 1'b0;
    else        sel_err <= multi_sel | (sel_err & ~clr_status);
  end
`else
  assign sel_eff = load_ctrl[6:0];
  assign sel_err = 1'b0;
`endif

  // Register file: a load takes priority over an increment of the same register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r  <= '0;
      ar <= '0;
      dr <= '0;
      ac <= '0;
      pc <= '0;
      ir <= '0;
    end else begin
      if (sel_eff[0])      r <= bus_data;
      else if (inc_ctrl[2]) r <= wrap_inc(r);
      if (sel_eff[1])      ar <= bus_data;
      else if (inc_ctrl[0]) ar <= wrap_inc(ar);
      if (sel_eff[2])      dr <= bus_data;
      if (sel_eff[3])      ac <= bus_data;
      if (sel_eff[4])      pc <= bus_data;
      else if (inc_ctrl[1]) pc <= wrap_inc(pc);
      if (sel_eff[5])      ir <= bus_data;
    end
  end

  // Write FSM: REQ lasts until ack or WR_TIMEOUT cycles have elapsed
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_start = 1'b0;
    drop_set = 1'b0;
    to_set   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_eff[6]) begin
          state_d  = REQ;
          cnt_d    = 8'd0;
          wr_start = 1'b1;
        end
      end
      REQ: begin
        drop_set = sel_eff[6];
        if (dram_ack) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == TO_LAST) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          to_set  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      dram_waddr <= '0;
      dram_wdata <= '0;
      wr_drop    <= 1'b0;
      wr_timeout <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_drop    <= drop_set | (wr_drop & ~clr_status);
      wr_timeout <= to_set | (wr_timeout & ~clr_status);
      if (wr_start) begin
        dram_waddr <= ar;
        dram_wdata <= bus_data;
      end
    end
  end

  // Request is decoded from the state so an async reset drops it at once
  assign dram_req = (state_q == REQ);
  assign busy     = (state_q == REQ);

endmodule

// File: tb/tb_bus_load_unit.sv
// Self-checking bench for bus_load_unit: directed literal checks plus randomized traffic against a behavioural model.
module tb_bus_load_unit;

  localparam int DATA_W     = 16;
  localparam int WR_TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] bus_data = '0;
  logic [7:0]        load_ctrl = '0;
  logic [2:0]        inc_ctrl = '0;
  logic              clr_status = 1'b0;
  logic              dram_ack = 1'b0;
  logic [DATA_W-1:0] r, ar, dr, ac, pc, ir, dram_waddr, dram_wdata;
  logic              dram_req, busy, wr_drop, wr_timeout, sel_err;

  bus_load_unit #(.DATA_W(DATA_W), .WR_TIMEOUT(WR_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .bus_data(bus_data), .load_ctrl(load_ctrl),
    .inc_ctrl(inc_ctrl), .clr_status(clr_status), .dram_ack(dram_ack),
    .r(r), .ar(ar), .dr(dr), .ac(ac), .pc(pc), .ir(ir),
    .dram_req(dram_req), .dram_waddr(dram_waddr), .dram_wdata(dram_wdata),
    .busy(busy), .wr_drop(wr_drop), .wr_timeout(wr_timeout), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  bit cmp_en = 0;

  // Model state: index 0 R, 1 AR, 2 DR, 3 AC, 4 PC, 5 IR
  logic [15:0] m_reg [0:5];
  logic [15:0] m_waddr, m_wdata;
  bit          m_busy, m_drop, m_to, m_sel;
  int          m_age;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_reg[i] = '0;
    m_waddr = '0; m_wdata = '0;
    m_busy = 0; m_drop = 0; m_to = 0; m_sel = 0; m_age = 0;
  endtask

  task automatic model_edge(input logic [7:0] ld, input logic [2:0] inc, input logic [15:0] bus,
                            input bit ack, input bit clr);
    logic [6:0]  eff;
    logic [15:0] ar_old;
    bit          was_busy, drop_s, to_s, sel_s;
    eff = ld[6:0];
    sel_s = 0;
`ifdef BUS_ERR_CHK_EN
    if ($countones(ld[6:0]) > 1) begin
      eff = '0;
      sel_s = 1;
    end
`endif
    ar_old = m_reg[1];
    was_busy = m_busy;
    drop_s = 0;
    to_s = 0;
    if (m_busy) begin
      if (ack) m_busy = 0;
      else if (m_age + 1 == WR_TIMEOUT) begin
        m_busy = 0;
        to_s = 1;
      end else m_age++;
    end
    if (inc[0] && !eff[1]) m_reg[1] = m_reg[1] + 16'd1;
    if (inc[1] && !eff[4]) m_reg[4] = m_reg[4] + 16'd1;
    if (inc[2] && !eff[0]) m_reg[0] = m_reg[0] + 16'd1;
    for (int i = 0; i < 6; i++) if (eff[i]) m_reg[i] = bus;
    if (eff[6]) begin
      if (was_busy) drop_s = 1;
      else begin
        m_waddr = ar_old;
        m_wdata = bus;
        m_busy = 1;
        m_age = 0;
      end
    end
    m_drop = drop_s || (m_drop && !clr);
    m_to   = to_s || (m_to && !clr);
    m_sel  = sel_s || (m_sel && !clr);
  endtask

  task automatic step();
    logic [7:0]  ld;
    logic [2:0]  inc;
    logic [15:0] bus;
    bit          ack, clr;
    @(posedge clk);
    ld = load_ctrl; inc = inc_ctrl; bus = bus_data; ack = dram_ack; clr = clr_status;
    if (!rst_n) model_reset();
    else model_edge(ld, inc, bus, ack, clr);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("r", r, m_reg[0]);
      chk("ar", ar, m_reg[1]);
      chk("dr", dr, m_reg[2]);
      chk("ac", ac, m_reg[3]);
      chk("pc", pc, m_reg[4]);
      chk("ir", ir, m_reg[5]);
      chk("dram_req", {15'd0, dram_req}, {15'd0, m_busy});
      chk("busy", {15'd0, busy}, {15'd0, m_busy});
      chk("dram_waddr", dram_waddr, m_waddr);
      chk("dram_wdata", dram_wdata, m_wdata);
      chk("wr_drop", {15'd0, wr_drop}, {15'd0, m_drop});
      chk("wr_timeout", {15'd0, wr_timeout}, {15'd0, m_to});
      chk("sel_err", {15'd0, sel_err}, {15'd0, m_sel});
    end
  end

  initial begin
    int n;
    int k;
    step();
    step();
    cmp_en = 1;
    chk("rst r", r, 16'h0000);
    chk("rst pc", pc, 16'h0000);
    chk("rst dram_req", {15'd0, dram_req}, 16'h0000);
    chk("rst wr_timeout", {15'd0, wr_timeout}, 16'h0000);
    rst_n = 1'b1;

    load_ctrl = 8'h01; bus_data = 16'h1234; step(); load_ctrl = 8'h00;
    chk("load r", r, 16'h1234);
    chk("load r ar untouched", ar, 16'h0000);

    load_ctrl = 8'h10; bus_data = 16'hFFFF; step(); load_ctrl = 8'h00;
    inc_ctrl = 3'b010; step(); inc_ctrl = 3'b000;
    chk("pc wrap", pc, 16'h0000);
    load_ctrl = 8'h10; bus_data = 16'h0042; inc_ctrl = 3'b010; step();
    load_ctrl = 8'h00; inc_ctrl = 3'b000;
    chk("pc load beats inc", pc, 16'h0042);

    load_ctrl = 8'h02; bus_data = 16'h0100; step();
    load_ctrl = 8'h40; bus_data = 16'hBEEF; step(); load_ctrl = 8'h00;
    chk("wr req", {15'd0, dram_req}, 16'h0001);
    chk("wr addr", dram_waddr, 16'h0100);
    chk("wr data", dram_wdata, 16'hBEEF);
    step();
    step();
    chk("wr req cycle3", {15'd0, busy}, 16'h0001);
    dram_ack = 1'b1; step(); dram_ack = 1'b0;
    chk("ack req low", {15'd0, dram_req}, 16'h0000);
    chk("ack busy low", {15'd0, busy}, 16'h0000);

    load_ctrl = 8'h40; bus_data = 16'h1111; step(); load_ctrl = 8'h00;
    n = 0;
    while (dram_req === 1'b1 && n < 40) begin
      n++;
      step();
    end
    chk("timeout req cycles", 16'(n), 16'(WR_TIMEOUT));
    chk("timeout flag", {15'd0, wr_timeout}, 16'h0001);
    clr_status = 1'b1; step(); clr_status = 1'b0;
    chk("timeout cleared", {15'd0, wr_timeout}, 16'h0000);

    load_ctrl = 8'h40; bus_data = 16'h2222; step();
    load_ctrl = 8'h48; bus_data = 16'h0007; step(); load_ctrl = 8'h00;
`ifdef BUS_ERR_CHK_EN
    chk("drop ac suppressed", ac, 16'h0000);
    chk("drop flag", {15'd0, wr_drop}, 16'h0000);
`else
    chk("drop ac", ac, 16'h0007);
    chk("drop flag", {15'd0, wr_drop}, 16'h0001);
`endif
    chk("drop wdata kept", dram_wdata, 16'h2222);
    dram_ack = 1'b1; step(); dram_ack = 1'b0;
    clr_status = 1'b1; step(); clr_status = 1'b0;
    chk("drop cleared", {15'd0, wr_drop}, 16'h0000);

    load_ctrl = 8'h06; bus_data = 16'hA5A5; step(); load_ctrl = 8'h00;
`ifdef BUS_ERR_CHK_EN
    chk("multi ar", ar, 16'h0100);
    chk("multi dr", dr, 16'h0000);
    chk("multi sel_err", {15'd0, sel_err}, 16'h0001);
`else
    chk("multi ar", ar, 16'hA5A5);
    chk("multi dr", dr, 16'hA5A5);
    chk("multi sel_err", {15'd0, sel_err}, 16'h0000);
`endif

    load_ctrl = 8'h40; bus_data = 16'h3333; step(); load_ctrl = 8'h00;
    chk("pre-reset req", {15'd0, dram_req}, 16'h0001);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async reset req", {15'd0, dram_req}, 16'h0000);
    chk("async reset ar", ar, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      k = $urandom_range(0, 9);
      if (k < 4)      load_ctrl = 8'h00;
      else if (k < 8) load_ctrl = 8'(1 << $urandom_range(0, 7));
      else            load_ctrl = 8'($urandom);
      inc_ctrl   = 3'($urandom);
      bus_data   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      dram_ack   = ($urandom_range(0, 19) == 0);
      clr_status = ($urandom_range(0, 15) == 0);
      step();
    end
    load_ctrl = 8'h00; inc_ctrl = 3'b000; dram_ack = 1'b0; clr_status = 1'b0;
    step();
    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
